// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/sub unit.
//   state_e  : controller states (idle, bit-shifting, result-ready)
//   MODE_ADD : mode value selecting a + b
//   MODE_SUB : mode value selecting a - b (b inverted, carry-in of one)
package addsub_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used for the per-clock step of serial_addsub.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : launch request (accepted in idle or in the done cycle)
//   mode       : 0 = a + b, 1 = a - b; sampled with start
//   a, b       : operands; sampled with start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when sum/cout/ovf update
//   sum        : registered result, held until the next done
//   cout       : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        : signed overflow (carry into MSB xor carry out of MSB)
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, done_q;

    logic             sub_sel;
    logic [WIDTH-1:0] b_in;
    logic             fa_a, fa_b, fa_ci, fa_s, fa_co;

    // Subtract is a + ~b + 1: invert b on load and seed the carry with one.
    assign sub_sel = (mode == MODE_SUB);
    assign b_in    = b ^ {WIDTH{sub_sel}};

    full_adder u_fa (
        .a  (fa_a),
        .b  (fa_b),
        .ci (fa_ci),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        fa_a    = a_q[0];
        fa_b    = b_q[0];
        fa_ci   = carry_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_in;
                    carry_d = sub_sel;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end

            StShift: begin
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // MSB step: carry_q is the carry into the MSB.
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
                if (start) begin
                    // Back-to-back launch folds the LSB step of the new operands
                    // into the load, so results come out every WIDTH cycles.
                    fa_a    = a[0];
                    fa_b    = b_in[0];
                    fa_ci   = sub_sel;
                    a_d     = a >> 1;
                    b_d     = b_in >> 1;
                    acc_d   = {fa_s, {(WIDTH - 1){1'b0}}};
                    carry_d = fa_co;
                    cnt_d   = CNT_W'(1);
                    state_d = StShift;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == StShift);
            done_q  <= (state_d == StDone);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=4 and WIDTH=8.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start4, mode4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;
    logic       start8, mode8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state, index 0 = WIDTH 4, index 1 = WIDTH 8.
    int         cyc[2];
    int         busy_until[2];   // edge at which the running op reports done
    bit         pend_v[2];
    int         pend_edge[2];
    logic [7:0] pend_sum[2];
    bit         pend_cout[2], pend_ovf[2];
    logic [7:0] exp_sum[2];
    bit         exp_cout[2], exp_ovf[2], exp_done[2], exp_busy[2];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain modular/signed arithmetic reference.
    function automatic void ref_op(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input bit m, output logic [7:0] s, output bit co,
                                   output bit ov);
        int modv, ua, ub, sa, sb, full, r;
        modv = 1 << w;
        ua   = int'(a) % modv;
        ub   = int'(b) % modv;
        sa   = (ua >= modv / 2) ? ua - modv : ua;
        sb   = (ub >= modv / 2) ? ub - modv : ub;
        if (!m) begin
            full = ua + ub;
            co   = (full >= modv);
            r    = sa + sb;
        end else begin
            full = ua - ub;
            co   = (ua >= ub);
            r    = sa - sb;
        end
        s  = 8'(((full % modv) + modv) % modv);
        ov = (r > modv / 2 - 1) || (r < -(modv / 2));
    endfunction

    task automatic model_reset(input int i);
        exp_sum[i]    = '0;
        exp_cout[i]   = 1'b0;
        exp_ovf[i]    = 1'b0;
        exp_done[i]   = 1'b0;
        exp_busy[i]   = 1'b0;
        pend_v[i]     = 1'b0;
        busy_until[i] = -100;
    endtask

    // One rising edge: retire a finished op, then decide whether start is accepted.
    // A launch in the done cycle completes WIDTH-1 edges later; from idle, WIDTH.
    task automatic model_edge(input int i, input int w, input bit st, input bit m,
                              input logic [7:0] a, input logic [7:0] b);
        int de;
        cyc[i]++;
        exp_done[i] = 1'b0;
        if (pend_v[i] && cyc[i] == pend_edge[i]) begin
            exp_sum[i]  = pend_sum[i];
            exp_cout[i] = pend_cout[i];
            exp_ovf[i]  = pend_ovf[i];
            exp_done[i] = 1'b1;
            pend_v[i]   = 1'b0;
        end
        if (st && cyc[i] > busy_until[i]) begin
            de = (cyc[i] == busy_until[i] + 1) ? cyc[i] + w - 1 : cyc[i] + w;
            ref_op(w, a, b, m, pend_sum[i], pend_cout[i], pend_ovf[i]);
            pend_v[i]     = 1'b1;
            pend_edge[i]  = de;
            busy_until[i] = de;
        end
        exp_busy[i] = pend_v[i] && (cyc[i] < pend_edge[i]);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset(0);
        else        model_edge(0, 4, start4, mode4, {4'b0, a4}, {4'b0, b4});
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset(1);
        else        model_edge(1, 8, start8, mode8, a8, b8);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("w4.busy", 8'(busy4), 8'(exp_busy[0]));
            chk("w4.done", 8'(done4), 8'(exp_done[0]));
            chk("w4.sum",  8'(sum4),  exp_sum[0]);
            chk("w4.cout", 8'(cout4), 8'(exp_cout[0]));
            chk("w4.ovf",  8'(ovf4),  8'(exp_ovf[0]));
            chk("w8.busy", 8'(busy8), 8'(exp_busy[1]));
            chk("w8.done", 8'(done8), 8'(exp_done[1]));
            chk("w8.sum",  sum8,      exp_sum[1]);
            chk("w8.cout", 8'(cout8), 8'(exp_cout[1]));
            chk("w8.ovf",  8'(ovf8),  8'(exp_ovf[1]));
        end
    end

    // Directed op on the 4-bit unit with hand-computed expectations.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit m,
                        input logic [3:0] es, input bit eco, input bit eov, input string nm);
        int lat;
        @(posedge clk); #1;
        start4 = 1'b1; a4 = a; b4 = b; mode4 = m;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done4 && lat < 20);
        chk({nm, ".lat"},  8'(lat),  8'd4);
        chk({nm, ".sum"},  8'(sum4), 8'(es));
        chk({nm, ".cout"}, 8'(cout4), 8'(eco));
        chk({nm, ".ovf"},  8'(ovf4), 8'(eov));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, nd, nd4, nd8;
        rst_n = 1'b0;
        start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
        model_reset(0);
        model_reset(1);
        cyc[0] = 0;
        cyc[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst.sum",  8'(sum4),  8'd0);
        chk("rst.busy", 8'(busy4), 8'd0);
        chk("rst.done", 8'(done4), 8'd0);
        rst_n = 1'b1;

        run4(4'h1, 4'h2, 1'b0, 4'b0011, 1'b0, 1'b0, "add1_2");
        run4(4'h4, 4'h6, 1'b0, 4'b1010, 1'b0, 1'b1, "add4_6");
        run4(4'hC, 4'hA, 1'b0, 4'b0110, 1'b1, 1'b1, "addC_A");
        run4(4'h1, 4'h2, 1'b1, 4'b1111, 1'b0, 1'b0, "sub1_2");
        run4(4'h4, 4'h6, 1'b1, 4'b1110, 1'b0, 1'b0, "sub4_6");
        run4(4'hC, 4'hA, 1'b1, 4'b0010, 1'b1, 1'b0, "subC_A");
        run4(4'h8, 4'h1, 1'b1, 4'b0111, 1'b1, 1'b1, "sub8_1");

        // Start during SHIFT is ignored.
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'h3; b4 = 4'h3; mode4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        nb = 0;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy4) nb++;
            if (done4) nd++;
            if (c == 1) begin
                start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
            end else begin
                start4 = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("ignore.ndone", 8'(nd),   8'd1);
        chk("ignore.nbusy", 8'(nb),   8'd4);
        chk("ignore.sum",   8'(sum4), 8'h6);

        // Back-to-back launch from the done cycle.
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'h1; b4 = 4'h1; mode4 = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done4 && lat < 20);
        chk("b2b.lat1", 8'(lat),  8'd4);
        chk("b2b.sum1", 8'(sum4), 8'h2);
        a4 = 4'h5; b4 = 4'h3; mode4 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done4 && lat < 20);
        start4 = 1'b0;
        chk("b2b.lat2", 8'(lat),   8'd4);
        chk("b2b.sum2", 8'(sum4),  8'h2);
        chk("b2b.cout", 8'(cout4), 8'd1);

        // Reset mid-operation aborts and clears outputs.
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'h7; b4 = 4'h7; mode4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort.sum",  8'(sum4),  8'd0);
        chk("abort.cout", 8'(cout4), 8'd0);
        chk("abort.busy", 8'(busy4), 8'd0);
        chk("abort.done", 8'(done4), 8'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done4) nd++;
        end
        chk("abort.nodone", 8'(nd), 8'd0);
        run4(4'h2, 4'h2, 1'b0, 4'b0100, 1'b0, 1'b0, "add2_2");

        // Random regression on both widths against the model.
        nd4 = 0;
        nd8 = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (done4) nd4++;
            if (done8) nd8++;
            start4 = ($urandom_range(0, 2) == 0);
            mode4  = 1'($urandom);
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            start8 = ($urandom_range(0, 3) == 0);
            mode8  = 1'($urandom);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
        end
        start4 = 1'b0;
        start8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rand.w4_activity", 8'(nd4 >= 20), 8'd1);
        chk("rand.w8_activity", 8'(nd8 >= 20), 8'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial two's-complement adder/subtractor with a start/done handshake. It computes the same function as the team's combinational 4-bit add/sub unit: `mode` plays the role of `cin`, selecting add or subtract. It processes one bit per clock, LSB first, which trades latency for area on wide operands. It sits behind a register-mapped controller that launches an operation and collects the registered result.

## Interface
- `WIDTH`, default 4: operand and result width in bits, ≥2.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: launch request, sampled on the rising edge.
- `mode`, input, 1: 0 = add (a+b), 1 = subtract (a−b); sampled with `start`.
- `a`, input, WIDTH: operand A; sampled with `start`.
- `b`, input, WIDTH: operand B; sampled with `start`.
- `busy`, output, 1: high while bits are being processed.
- `done`, output, 1: one-cycle pulse when the result registers update.
- `sum`, output, WIDTH: result, registered, held until the next `done`.
- `cout`, output, 1: final carry out. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- `ovf`, output, 1: signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**: on `start`=1, latch the working registers and go to SHIFT:
  - `a`.
  - `b` XOR {WIDTH{`mode`}}.
  - carry = `mode`.
  - bit counter = 0.
- **SHIFT**: each cycle, one full-adder step on the operand LSBs and the carry register.
  - The sum bit shifts into the result shift register from the MSB side.
  - Operands shift right and the counter increments.
  - The carry into the MSB step is captured for `ovf`.
  - After the step with counter = WIDTH−1, go to DONE.
- **DONE**: lasts one cycle with `done`=1.
  - `sum`, `cout` and `ovf` are loaded on the transition into DONE.
  - Next state is IDLE. If `start`=1 in DONE, go directly to SHIFT with new operands (back-to-back operation).
- `start` in SHIFT is ignored: no queueing and no effect on the running operation.
- Internal partial results are never visible on `sum`. Outputs change only on entry to DONE.
- Arithmetic is modulo 2^WIDTH. `cout` and `ovf` are reported; they are not saturated or sticky.

## Timing
- Reset (async assert, sync release on `clk`):
  - state IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - all internal registers 0.
- Reset asserted mid-operation aborts immediately. No `done` is issued, and the prior result is lost (outputs go to 0).
- Latency: with `start` sampled at edge k, `busy`=1 from edge k through edge k+WIDTH. At edge k+WIDTH, `done`=1, the outputs are valid, and `busy`=0.
  - For WIDTH=4, `done` is high during cycle k+4.
- `busy` is a registered decode of SHIFT, asserted the cycle after `start`.
- Throughput: one result per WIDTH+1 cycles, or per WIDTH cycles when issuing back-to-back from DONE.
- `done` is never high for two consecutive cycles.

## Structure
- Shared package `addsub_pkg`:
  - state enum (IDLE/SHIFT/DONE).
  - `MODE_ADD`=1'b0 and `MODE_SUB`=1'b1.
  - counter width as `$clog2(WIDTH)`, computed in the module from the parameter.
- One sub-module, `full_adder` (a, b, ci → s, co), instantiated once for the per-bit step.
- Everything else (FSM, counter, shift registers, output registers) lives in `serial_addsub`.

## Test plan
- Add, WIDTH=4:
  - 1+2 → `sum`=0011, `cout`=0, `ovf`=0.
  - 4+6 → `sum`=1010, `cout`=0, `ovf`=1.
  - C+A → `sum`=0110, `cout`=1, `ovf`=1.
  - Each has `done` exactly 4 cycles after `start`.
- Subtract, WIDTH=4:
  - 1−2 → `sum`=1111, `cout`=0, `ovf`=0.
  - 4−6 → `sum`=1110, `cout`=0, `ovf`=0.
  - C−A → `sum`=0010, `cout`=1, `ovf`=0.
  - 8−1 → `sum`=0111, `ovf`=1.
- Pulse `start` with 3+3 and again 2 cycles later with F+F → only one `done`, with `sum`=0110; `busy` high 4 cycles.
- Hold `start` high from the first launch, with operands changed to 5−3 in the DONE cycle → second `done` exactly 4 cycles after the first, with `sum`=0010, `cout`=1.
- Launch 7+7, then assert `rst_n`=0 two cycles later → all outputs 0 immediately and no `done`. A fresh 2+2 after release → `sum`=0100.
- Random regression at WIDTH=4 and WIDTH=8 against a behavioural a±b model: `sum`, `cout` and `ovf` match for every `done`, and `sum` is stable between `done` pulses.
